// File: rtl/binary_morph3x3.sv
// Streaming 3x3 binary morphology filter (erode / dilate / majority by THRESH).
// Two 1-bit line buffers feed a 3-column window; the ones-count is compared
// against THRESH and border pixels are forced to 0. Fixed latency of 3 cycles.
// en = 0 bypasses the filter with identical latency and no border forcing.
module binary_morph3x3 #(
  parameter int unsigned H_START = 169,
  parameter int unsigned V_START = 51,
  parameter int unsigned LINE_W  = 2048,
  parameter int unsigned THRESH  = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ie,
  input  logic [10:0] hcnt,
  input  logic [9:0]  vcnt,
  input  logic        idat,
  output logic        oe,
  output logic [10:0] ohcnt,
  output logic [9:0]  ovcnt,
  output logic        odat
);

  localparam int unsigned AW   = $clog2(LINE_W);
  localparam logic [10:0] HMin = 11'(H_START + 2);
  localparam logic [9:0]  VMin = 10'(V_START + 2);
  localparam logic [3:0]  Thr  = 4'(THRESH);

  // Line buffers: lb0 holds row v-1, lb1 holds row v-2. Not reset.
  logic lb0_q [LINE_W];
  logic lb1_q [LINE_W];

  logic [AW-1:0] addr;
  logic          lb0_rd;
  logic          lb1_rd;
  logic [2:0]    col;

  assign addr   = hcnt[AW-1:0];
  assign lb0_rd = lb0_q[addr];
  assign lb1_rd = lb1_q[addr];
  assign col    = {lb1_rd, lb0_rd, idat};

  // Stage 1: window and qualifiers
  logic [8:0]  win_q, win_d;
  logic        s1_ie_q, s1_en_q, s1_dat_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;
  // Stage 2: threshold result
  logic        s2_ie_q, s2_en_q, s2_res_q, s2_res_d;
  logic [10:0] s2_h_q;
  logic [9:0]  s2_v_q;
  // Stage 3: outputs
  logic        oe_q, odat_q, odat_d;
  logic [10:0] ohcnt_q;
  logic [9:0]  ovcnt_q;
  logic [3:0]  cnt;

  // Line-buffer update: read-before-write, old row v-1 entry shifts into row v-2.
  always_ff @(posedge clk) begin
    if (ie) begin
      lb0_q[addr] <= idat;
      lb1_q[addr] <= lb0_rd;
    end
  end

  // Next-state: window shift on valid pixels, popcount, threshold, border forcing.
  always_comb begin
    win_d = win_q;
    if (ie) begin
      win_d = {win_q[5:0], col};
    end
    cnt = '0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + 4'(win_q[i]);
    end
    // Bypass carries the raw pixel through the same stages.
    s2_res_d = s1_ie_q & (s1_en_q ? (cnt >= Thr) : s1_dat_q);
    // Border rows/columns would see stale previous-line or previous-frame data.
    odat_d = s2_ie_q & s2_res_q & (~s2_en_q | ((s2_h_q >= HMin) & (s2_v_q >= VMin)));
  end

  // Pipeline registers; all reset asynchronously to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      s1_ie_q  <= 1'b0;
      s1_en_q  <= 1'b0;
      s1_dat_q <= 1'b0;
      s1_h_q   <= '0;
      s1_v_q   <= '0;
      s2_ie_q  <= 1'b0;
      s2_en_q  <= 1'b0;
      s2_res_q <= 1'b0;
      s2_h_q   <= '0;
      s2_v_q   <= '0;
      oe_q     <= 1'b0;
      odat_q   <= 1'b0;
      ohcnt_q  <= '0;
      ovcnt_q  <= '0;
    end else begin
      win_q    <= win_d;
      s1_ie_q  <= ie;
      s1_en_q  <= en;
      s1_dat_q <= idat;
      s1_h_q   <= hcnt;
      s1_v_q   <= vcnt;
      s2_ie_q  <= s1_ie_q;
      s2_en_q  <= s1_en_q;
      s2_res_q <= s2_res_d;
      s2_h_q   <= s1_h_q;
      s2_v_q   <= s1_v_q;
      oe_q     <= s2_ie_q;
      odat_q   <= odat_d;
      ohcnt_q  <= s2_h_q;
      ovcnt_q  <= s2_v_q;
    end
  end

  assign oe    = oe_q;
  assign odat  = odat_q;
  assign ohcnt = ohcnt_q;
  assign ovcnt = ovcnt_q;

endmodule

// File: tb/tb_binary_morph3x3.sv
// Self-checking bench: three filter instances (THRESH 9, 1, 5) share one stimulus stream.
// A 2-D image model predicts every output cycle; directed frames are also checked
// against a table of hand-derived pixel values.
module tb_binary_morph3x3;

  localparam int HS = 169;
  localparam int VS = 51;
  localparam int FW = 32;
  localparam int FH = 16;

  function automatic int th_of(input int g);
    return (g == 0) ? 9 : ((g == 1) ? 1 : 5);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n, en, ie, idat;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [2:0]  oe_w, od_w;
  logic [10:0] oh_w [3];
  logic [9:0]  ov_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    binary_morph3x3 #(.THRESH(th_of(g))) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .ie   (ie),
      .hcnt (hcnt),
      .vcnt (vcnt),
      .idat (idat),
      .oe   (oe_w[g]),
      .ohcnt(oh_w[g]),
      .ovcnt(ov_w[g]),
      .odat (od_w[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic        oe;
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  d;
  } exp_t;

  typedef struct {
    int         fr;
    int         h;
    int         v;
    logic [2:0] d;  // {T5, T1, T9}
  } vec_t;

  exp_t       q[$];
  bit         chk_en = 1'b0;
  logic       img  [FH][FW];
  logic [2:0] omap [FH][FW];
  logic [2:0] rmap [FH][FW];
  vec_t       tbl  [18];

  // Reference: window of rows v-2..v, columns h-2..h from the current frame image.
  function automatic logic model(input int g, input int h, input int v, input logic e,
                                 input logic d);
    int c;
    c = 0;
    if (!e) return d;
    if (h < HS + 2 || v < VS + 2) return 1'b0;
    for (int dv = 0; dv < 3; dv++)
      for (int dh = 0; dh < 3; dh++)
        c += int'(img[v - VS - dv][h - HS - dh]);
    return c >= th_of(g);
  endfunction

  // Predict the output for the inputs sampled on this edge.
  always @(posedge clk) begin : mon
    exp_t e;
    int hi, vi;
    if (chk_en) begin
      e.oe = ie;
      e.h  = hcnt;
      e.v  = vcnt;
      e.d  = 3'b000;
      hi = int'(hcnt) - HS;
      vi = int'(vcnt) - VS;
      if (ie && hi >= 0 && hi < FW && vi >= 0 && vi < FH) begin
        img[vi][hi] = idat;
        for (int g = 0; g < 3; g++) e.d[g] = model(g, int'(hcnt), int'(vcnt), en, idat);
      end
      q.push_back(e);
    end
  end

  // Compare three cycles later and capture the output map.
  always @(negedge clk) begin : chkr
    exp_t e;
    int hi, vi;
    if (chk_en && q.size() >= 3) begin
      e = q.pop_front();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("oe[T%0d]", th_of(g)), 32'(oe_w[g]), 32'(e.oe));
        chk($sformatf("ohcnt[T%0d]", th_of(g)), 32'(oh_w[g]), 32'(e.h));
        chk($sformatf("ovcnt[T%0d]", th_of(g)), 32'(ov_w[g]), 32'(e.v));
        chk($sformatf("odat[T%0d] at (%0d,%0d)", th_of(g), e.h, e.v), 32'(od_w[g]),
            32'(e.d[g]));
      end
    end
    if (oe_w[0]) begin
      hi = int'(oh_w[0]) - HS;
      vi = int'(ov_w[0]) - VS;
      if (hi >= 0 && hi < FW && vi >= 0 && vi < FH) omap[vi][hi] = od_w;
    end
  end

  task automatic cyc(input logic i, input int h, input int v, input logic e, input logic d);
    ie   = i;
    hcnt = 11'(h);
    vcnt = 10'(v);
    en   = e;
    idat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // kind: 0 all ones, 1 directed sparse, 2 random filtered, 3 random bypass, 4 random mixed en
  task automatic frame(input int kind, input bit gap);
    logic d, e;
    for (int v = 0; v < FH; v++)
      for (int h = 0; h < FW; h++)
        omap[v][h] = 3'bxxx;
    for (int v = 0; v < FH; v++) begin
      for (int h = 0; h < FW; h++) begin
        if (gap) idle();
        e = 1'b1;
        case (kind)
          0: d = 1'b1;
          1: d = ((HS + h == 180) && (VS + v == 60)) ||
                 ((HS + h >= 186) && (HS + h <= 188) && (VS + v >= 60) && (VS + v <= 61));
          3: begin d = 1'($urandom_range(0, 1)); e = 1'b0; end
          4: begin d = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1)); end
          default: d = 1'($urandom_range(0, 1));
        endcase
        cyc(1'b1, HS + h, VS + v, e, d);
      end
      repeat (4) idle();
    end
  endtask

  task automatic check_table(input int fid);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].fr == fid)
        chk($sformatf("map{T5,T1,T9}(%0d,%0d)", tbl[i].h, tbl[i].v),
            32'(omap[tbl[i].v - VS][tbl[i].h - HS]), 32'(tbl[i].d));
    end
  endtask

  initial begin
    int lat, mism;
    tbl[0]  = '{1, 180, 60, 3'b010};
    tbl[1]  = '{1, 182, 62, 3'b010};
    tbl[2]  = '{1, 181, 61, 3'b010};
    tbl[3]  = '{1, 183, 61, 3'b000};
    tbl[4]  = '{1, 179, 60, 3'b000};
    tbl[5]  = '{1, 180, 63, 3'b000};
    tbl[6]  = '{1, 188, 61, 3'b110};
    tbl[7]  = '{1, 188, 62, 3'b110};
    tbl[8]  = '{1, 187, 61, 3'b010};
    tbl[9]  = '{1, 189, 62, 3'b010};
    tbl[10] = '{1, 190, 63, 3'b010};
    tbl[11] = '{1, 191, 61, 3'b000};
    tbl[12] = '{1, 188, 60, 3'b010};
    tbl[13] = '{0, 170, 60, 3'b000};
    tbl[14] = '{0, 171, 53, 3'b111};
    tbl[15] = '{0, 171, 52, 3'b000};
    tbl[16] = '{0, 200, 66, 3'b111};
    tbl[17] = '{0, 185, 51, 3'b000};

    rst_n = 1'b0;
    ie = 1'b0; en = 1'b0; idat = 1'b0; hcnt = '0; vcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset oe", 32'(oe_w[g]), 32'd0);
      chk("reset ohcnt", 32'(oh_w[g]), 32'd0);
      chk("reset ovcnt", 32'(ov_w[g]), 32'd0);
      chk("reset odat", 32'(od_w[g]), 32'd0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    frame(0, 1'b0);
    check_table(0);
    rmap = omap;
    frame(0, 1'b1);
    mism = 0;
    for (int v = 0; v < FH; v++)
      for (int h = 0; h < FW; h++)
        if (omap[v][h] !== rmap[v][h]) mism++;
    chk("gapped vs continuous map mismatches", 32'(mism), 32'd0);
    frame(1, 1'b0);
    check_table(1);
    frame(3, 1'b0);
    frame(2, 1'b0);
    frame(4, 1'b0);
    frame(4, 1'b1);

    // Mid-line reset
    chk_en = 1'b0;
    q.delete();
    cyc(1'b1, 398, 60, 1'b1, 1'b1);
    cyc(1'b1, 399, 60, 1'b1, 1'b1);
    cyc(1'b1, 400, 60, 1'b1, 1'b1);
    chk("pre-reset oe", 32'(oe_w[0]), 32'd1);
    chk("pre-reset ohcnt", 32'(oh_w[0]), 32'd398);
    #2;
    ie = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("async reset oe", 32'(oe_w[g]), 32'd0);
      chk("async reset ohcnt", 32'(oh_w[g]), 32'd0);
      chk("async reset ovcnt", 32'(ov_w[g]), 32'd0);
      chk("async reset odat", 32'(od_w[g]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("post-reset idle oe", 32'(oe_w[0]), 32'd0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk("post-reset idle oe", 32'(oe_w[0]), 32'd0);
    cyc(1'b1, 401, 60, 1'b1, 1'b1);
    lat = 1;
    while (oe_w[0] !== 1'b1 && lat < 8) begin
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      lat++;
    end
    chk("first oe latency after reset", 32'(lat), 32'd3);
    chk("first ohcnt after reset", 32'(oh_w[0]), 32'd401);
    repeat (3) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    chk_en = 1'b1;
    frame(4, 1'b0);
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
